// File: rtl/rv_pipe_pkg.sv
// Shared definitions for the RV32I front-end pipeline.
// Encodings, reset defaults and inter-stage bundles.
package rv_pipe_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    localparam logic [1:0] PCSRC_PLUS4 = 2'd0;
    localparam logic [1:0] PCSRC_TGT   = 2'd1;
    localparam logic [1:0] PCSRC_JALR  = 2'd2;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } if_id_t;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] immext;
        logic [31:0] pc;
        logic [31:0] pcplus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } id_ex_t;

    localparam if_id_t IF_ID_CLR = '{
        instr:   NOP_INSTR,
        pc:      32'd0,
        pcplus4: 32'd0
    };

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register with enable and synchronous clear.
// Reset and clear load the same value; clear wins over enable.
module pipe_reg #(
    parameter int           W       = 32,
    parameter logic [W-1:0] CLR_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q <= CLR_VAL;
        end else if (clr) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_front_ctrl.sv
// Front-end sequencer: PC, IF/ID and ID/EX registers plus
// load-use stall / control-flush handling and event counters.
module pipe_front_ctrl
    import rv_pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int          CTRL_W   = 12,
    parameter int          CNT_W    = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              STALL_i,
    input  logic              FLUSH_i,
    input  logic [1:0]        PC_SRC_E_i,
    input  logic [31:0]       PC_TARGET_E_i,
    input  logic [31:0]       ALU_RSLT_E_i,
    input  logic [31:0]       INSTR_F_i,
    input  logic [CTRL_W-1:0] CTRL_D_i,
    input  logic [31:0]       RD1_D_i,
    input  logic [31:0]       RD2_D_i,
    input  logic [31:0]       IMMEXT_D_i,
    output logic [31:0]       PC_F_o,
    output logic [31:0]       INSTR_D_o,
    output logic [31:0]       PC_D_o,
    output logic [31:0]       PCPLUS4_D_o,
    output logic [4:0]        RS1_D_o,
    output logic [4:0]        RS2_D_o,
    output logic [CTRL_W-1:0] CTRL_E_o,
    output logic [31:0]       RD1_E_o,
    output logic [31:0]       RD2_E_o,
    output logic [31:0]       IMMEXT_E_o,
    output logic [31:0]       PC_E_o,
    output logic [31:0]       PCPLUS4_E_o,
    output logic [4:0]        RS1_E_o,
    output logic [4:0]        RS2_E_o,
    output logic [4:0]        RD_E_o,
    output logic [CNT_W-1:0]  STALL_CNT_o,
    output logic [CNT_W-1:0]  FLUSH_CNT_o
);

    logic [31:0] pc_f;
    logic [31:0] pc_plus4_f;
    logic [31:0] pc_tgt;
    logic [31:0] pc_next;
    if_id_t      if_id_d, if_id_q;
    id_ex_t      id_ex_d, id_ex_q;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    assign pc_plus4_f = pc_f + 32'd4;

    // Selector value 11 falls back to sequential fetch
    always_comb begin
        pc_tgt = pc_plus4_f;
        case (PC_SRC_E_i)
            PCSRC_TGT:  pc_tgt = PC_TARGET_E_i;
            PCSRC_JALR: pc_tgt = {ALU_RSLT_E_i[31:1], 1'b0};
            default:    pc_tgt = pc_plus4_f;
        endcase
        pc_next = FLUSH_i ? pc_tgt : pc_plus4_f;
    end

    pipe_reg #(.W(32), .CLR_VAL(RESET_PC)) u_pc (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (FLUSH_i | ~STALL_i),
        .clr   (1'b0),
        .d     (pc_next),
        .q     (pc_f)
    );

    assign if_id_d = '{
        instr:   INSTR_F_i,
        pc:      pc_f,
        pcplus4: pc_plus4_f
    };

    pipe_reg #(.W($bits(if_id_t)), .CLR_VAL(IF_ID_CLR)) u_if_id (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (~STALL_i),
        .clr   (FLUSH_i),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign id_ex_d = '{
        rd1:     RD1_D_i,
        rd2:     RD2_D_i,
        immext:  IMMEXT_D_i,
        pc:      if_id_q.pc,
        pcplus4: if_id_q.pcplus4,
        rs1:     if_id_q.instr[19:15],
        rs2:     if_id_q.instr[24:20],
        rd:      if_id_q.instr[11:7]
    };

    pipe_reg #(.W($bits(id_ex_t)), .CLR_VAL('0)) u_id_ex (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (1'b1),
        .clr   (FLUSH_i | STALL_i),
        .d     (id_ex_d),
        .q     (id_ex_q)
    );

    pipe_reg #(.W(CTRL_W), .CLR_VAL('0)) u_ctrl_ex (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (1'b1),
        .clr   (FLUSH_i | STALL_i),
        .d     (CTRL_D_i),
        .q     (CTRL_E_o)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (STALL_i && !FLUSH_i && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (FLUSH_i && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign PC_F_o      = pc_f;
    assign INSTR_D_o   = if_id_q.instr;
    assign PC_D_o      = if_id_q.pc;
    assign PCPLUS4_D_o = if_id_q.pcplus4;
    assign RS1_D_o     = if_id_q.instr[19:15];
    assign RS2_D_o     = if_id_q.instr[24:20];
    assign RD1_E_o     = id_ex_q.rd1;
    assign RD2_E_o     = id_ex_q.rd2;
    assign IMMEXT_E_o  = id_ex_q.immext;
    assign PC_E_o      = id_ex_q.pc;
    assign PCPLUS4_E_o = id_ex_q.pcplus4;
    assign RS1_E_o     = id_ex_q.rs1;
    assign RS2_E_o     = id_ex_q.rs2;
    assign RD_E_o      = id_ex_q.rd;
    assign STALL_CNT_o = stall_cnt;
    assign FLUSH_CNT_o = flush_cnt;

endmodule
